// File: rtl/ram_rd_chk_if.sv
// Snoop bus between a RAM read port (port B) and the ram_rd_chk checker.
// err_inj is present only when RAM_RD_CHK_ERR_INJ_EN is defined.
interface ram_rd_chk_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
`ifdef RAM_RD_CHK_ERR_INJ_EN
    logic              err_inj;
`endif
    logic              chk_busy;
    logic              chk_done;
    logic              chk_pass;
    logic [ADDR_W:0]   err_cnt;
    logic [ADDR_W-1:0] first_err_addr;

    modport master (
`ifdef RAM_RD_CHK_ERR_INJ_EN
        output err_inj,
`endif
        output ram_rd_en, ram_rd_addr, ram_rd_data,
        input  chk_busy, chk_done, chk_pass, err_cnt, first_err_addr
    );

    modport slave (
`ifdef RAM_RD_CHK_ERR_INJ_EN
        input  err_inj,
`endif
        input  ram_rd_en, ram_rd_addr, ram_rd_data,
        output chk_busy, chk_done, chk_pass, err_cnt, first_err_addr
    );
endinterface

// File: rtl/ram_rd_chk.sv
// Read-back checker: compares RAM port B data against (addr + PAT_OFFSET) over 2^ADDR_W-word passes.
// Optional macro RAM_RD_CHK_ERR_INJ_EN adds err_inj, which flips the LSB of compared data.
module ram_rd_chk #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,   // legal range 1..3
    parameter int PAT_OFFSET = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    ram_rd_chk_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] WORDS   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ERR_MAX = '1;

    state_t            r_state;
    state_t            w_state_next;
    logic [RD_LAT-1:0] r_vld_pipe;
    logic [ADDR_W-1:0] r_addr_pipe [RD_LAT];
    logic [ADDR_W:0]   r_word_cnt,       w_word_next;
    logic [ADDR_W:0]   r_err_cnt,        w_err_next;
    logic [ADDR_W-1:0] r_first_err_addr, w_ferr_next;
    logic              r_done,           w_done_next;

    logic              w_cmp_vld;
    logic [ADDR_W-1:0] w_cmp_addr;
    logic [DATA_W-1:0] w_cmp_data;
    logic [DATA_W-1:0] w_exp;
    logic              w_mis;
    logic [ADDR_W:0]   w_err_sat;
    logic [ADDR_W:0]   w_word_inc;

    // Enable/address travel alongside the RAM read so they line up with ram_rd_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) r_addr_pipe[i] <= '0;
        end else begin
            r_vld_pipe[0]  <= bus.ram_rd_en;
            r_addr_pipe[0] <= bus.ram_rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_addr_pipe[i] <= r_addr_pipe[i-1];
            end
        end
    end

    assign w_cmp_vld  = r_vld_pipe[RD_LAT-1];
    assign w_cmp_addr = r_addr_pipe[RD_LAT-1];

`ifdef RAM_RD_CHK_ERR_INJ_EN
    assign w_cmp_data = bus.ram_rd_data ^ {{(DATA_W-1){1'b0}}, bus.err_inj & w_cmp_vld};
`else
    assign w_cmp_data = bus.ram_rd_data;
`endif

    assign w_exp      = DATA_W'(w_cmp_addr) + DATA_W'(PAT_OFFSET);
    assign w_mis      = w_cmp_vld && (w_cmp_data != w_exp);
    assign w_err_sat  = (r_err_cnt == ERR_MAX) ? r_err_cnt : r_err_cnt + ONE;
    assign w_word_inc = r_word_cnt + ONE;

    always_comb begin
        w_state_next = r_state;
        w_word_next  = r_word_cnt;
        w_err_next   = r_err_cnt;
        w_ferr_next  = r_first_err_addr;
        w_done_next  = r_done;
        case (r_state)
            IDLE, DONE: begin
                if (bus.ram_rd_en) begin
                    // A compare landing on the start edge is the new pass's first word
                    w_state_next = CHECK;
                    w_done_next  = 1'b0;
                    w_word_next  = w_cmp_vld ? ONE : '0;
                    w_err_next   = w_mis ? ONE : '0;
                    w_ferr_next  = w_mis ? w_cmp_addr : '0;
                end else if (r_state == DONE && w_mis) begin
                    w_err_next = w_err_sat;
                    if (r_err_cnt == '0) w_ferr_next = w_cmp_addr;
                end
            end
            CHECK: begin
                if (w_cmp_vld) begin
                    w_word_next = w_word_inc;
                    if (w_mis) begin
                        w_err_next = w_err_sat;
                        if (r_err_cnt == '0) w_ferr_next = w_cmp_addr;
                    end
                    if (w_word_inc == WORDS) begin
                        w_state_next = DONE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_word_cnt       <= '0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_done           <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_word_cnt       <= w_word_next;
            r_err_cnt        <= w_err_next;
            r_first_err_addr <= w_ferr_next;
            r_done           <= w_done_next;
        end
    end

    assign bus.chk_busy       = (r_state == CHECK);
    assign bus.chk_done       = r_done;
    assign bus.chk_pass       = r_done && (r_err_cnt == '0);
    assign bus.err_cnt        = r_err_cnt;
    assign bus.first_err_addr = r_first_err_addr;
endmodule

// File: tb/tb_ram_rd_chk.sv
// Directed bench for ram_rd_chk: two instances (RD_LAT=1 and RD_LAT=2) watch the same read stream.
// Each has its own behavioural RAM port with matching latency.
module tb_ram_rd_chk;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd_en = 1'b0;
    logic [5:0] rd_addr = '0;
    logic [7:0] mem [64];
    logic [7:0] rd_q1, rd_q2a, rd_q2b;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    ram_rd_chk_if #(.ADDR_W(6), .DATA_W(8)) bus1 ();
    ram_rd_chk_if #(.ADDR_W(6), .DATA_W(8)) bus2 ();

    assign bus1.ram_rd_en   = rd_en;
    assign bus1.ram_rd_addr = rd_addr;
    assign bus1.ram_rd_data = rd_q1;
    assign bus2.ram_rd_en   = rd_en;
    assign bus2.ram_rd_addr = rd_addr;
    assign bus2.ram_rd_data = rd_q2b;

    ram_rd_chk #(.ADDR_W(6), .DATA_W(8), .RD_LAT(1), .PAT_OFFSET(0)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    ram_rd_chk #(.ADDR_W(6), .DATA_W(8), .RD_LAT(2), .PAT_OFFSET(0)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // Idle cycles return junk that never equals a valid expected word
    always @(posedge clk) begin
        rd_q1  <= rd_en ? mem[rd_addr] : 8'hC3;
        rd_q2a <= rd_en ? mem[rd_addr] : 8'hC3;
        rd_q2b <= rd_q2a;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic do_read(input int a);
        rd_en   = 1'b1;
        rd_addr = 6'(a);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mem_clean();
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    endtask

    task automatic full_pass();
        for (int k = 0; k < 64; k++) do_read(k);
    endtask

    task automatic check_result(input string tag, input int exp_err, input int exp_ferr);
        check({tag, " done1"}, 32'(bus1.chk_done), 32'd1);
        check({tag, " done2"}, 32'(bus2.chk_done), 32'd1);
        check({tag, " pass1"}, 32'(bus1.chk_pass), 32'(exp_err == 0));
        check({tag, " pass2"}, 32'(bus2.chk_pass), 32'(exp_err == 0));
        check({tag, " err1"},  32'(bus1.err_cnt), 32'(exp_err));
        check({tag, " err2"},  32'(bus2.err_cnt), 32'(exp_err));
        check({tag, " ferr1"}, 32'(bus1.first_err_addr), 32'(exp_ferr));
        check({tag, " ferr2"}, 32'(bus2.first_err_addr), 32'(exp_ferr));
        $display("pass %s: err1=%0d err2=%0d ferr1=%0d ferr2=%0d", tag,
                 bus1.err_cnt, bus2.err_cnt, bus1.first_err_addr, bus2.first_err_addr);
    endtask

    initial begin
`ifdef RAM_RD_CHK_ERR_INJ_EN
        bus1.err_inj = 1'b0;
        bus2.err_inj = 1'b0;
`endif
        mem_clean();
        idle(3);

        // Reset state
        check("rst busy1", 32'(bus1.chk_busy), 32'd0);
        check("rst done1", 32'(bus1.chk_done), 32'd0);
        check("rst pass1", 32'(bus1.chk_pass), 32'd0);
        check("rst err1",  32'(bus1.err_cnt), 32'd0);
        check("rst done2", 32'(bus2.chk_done), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Clean pass: done exactly one cycle after the last compare
        do_read(0);
        check("clean busy1 start", 32'(bus1.chk_busy), 32'd1);
        for (int k = 1; k < 64; k++) do_read(k);
        check("clean done1 early", 32'(bus1.chk_done), 32'd0);
        idle(1);
        check("clean done1 on time", 32'(bus1.chk_done), 32'd1);
        check("clean pass1", 32'(bus1.chk_pass), 32'd1);
        check("clean busy1 end", 32'(bus1.chk_busy), 32'd0);
        check("clean done2 early", 32'(bus2.chk_done), 32'd0);
        idle(1);
        check_result("clean", 0, 0);

        // Single corrupt word
        mem[17] = 8'hFF;
        full_pass();
        idle(3);
        check_result("addr17", 1, 17);
        mem_clean();

        // Two corrupt words with read gaps; idle junk must not count
        mem[5]  = 8'h00;
        mem[40] = 8'h55;
        for (int k = 0; k < 64; k++) begin
            do_read(k);
            idle((k * 5 + 1) % 4);
            if (k == 30) begin
                idle(2);
                check("gaps mid err1", 32'(bus1.err_cnt), 32'd1);
                check("gaps mid err2", 32'(bus2.err_cnt), 32'd1);
                check("gaps mid busy1", 32'(bus1.chk_busy), 32'd1);
            end
        end
        idle(3);
        check_result("gaps", 2, 5);
        mem_clean();

        // Reset mid-pass abandons it
        mem[3] = 8'h00;
        for (int k = 0; k < 30; k++) do_read(k);
        idle(2);
        check("midrst err1 before", 32'(bus1.err_cnt), 32'd1);
        rst_n = 1'b0;
        #2;
        check("midrst err1 async", 32'(bus1.err_cnt), 32'd0);
        check("midrst busy1 async", 32'(bus1.chk_busy), 32'd0);
        check("midrst ferr2 async", 32'(bus2.first_err_addr), 32'd0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        check("midrst done1 idle", 32'(bus1.chk_done), 32'd0);
        mem[3]  = 8'd3;
        mem[50] = 8'h00;
        for (int k = 0; k < 64; k++) begin
            do_read(k);
            if (k == 0 || k == 63) begin
                check("midrst done1 during", 32'(bus1.chk_done), 32'd0);
                check("midrst done2 during", 32'(bus2.chk_done), 32'd0);
            end
        end
        idle(3);
        check_result("midrst", 1, 50);
        mem_clean();

        // Back-to-back passes, second starts the cycle after the last read
        full_pass();
        for (int k = 0; k < 64; k++) begin
            do_read(k);
            if (k == 0) begin
                check("b2b done1 A", 32'(bus1.chk_done), 32'd1);
                check("b2b pass1 A", 32'(bus1.chk_pass), 32'd1);
                check("b2b done2 pre", 32'(bus2.chk_done), 32'd0);
            end else if (k == 1) begin
                check("b2b done2 A", 32'(bus2.chk_done), 32'd1);
                check("b2b pass2 A", 32'(bus2.chk_pass), 32'd1);
                check("b2b busy1 B", 32'(bus1.chk_busy), 32'd1);
            end else if (k == 2) begin
                check("b2b done2 cleared", 32'(bus2.chk_done), 32'd0);
                check("b2b busy2 B", 32'(bus2.chk_busy), 32'd1);
            end
        end
        check("b2b done1 B early", 32'(bus1.chk_done), 32'd0);
        idle(1);
        check("b2b done1 B", 32'(bus1.chk_done), 32'd1);
        check("b2b done2 B early", 32'(bus2.chk_done), 32'd0);
        idle(1);
        check_result("b2b", 0, 0);

`ifdef RAM_RD_CHK_ERR_INJ_EN
        // Injected LSB flips on clean data at addresses 10..12
        for (int k = 0; k < 64; k++) begin
            do_read(k);
            bus1.err_inj = (k >= 10 && k <= 12);
            bus2.err_inj = (k >= 11 && k <= 13);
        end
        bus1.err_inj = 1'b0;
        idle(1);
        bus2.err_inj = 1'b0;
        idle(2);
        check_result("errinj", 3, 10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ram_rd_chk.md
RAM_RD_CHK -- requirements
Module: ram_rd_chk

Interface
REQ-001 Parameter ADDR_W, default 6, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 Parameter RD_LAT, default 1, RAM read latency in clk cycles from enb/addrb to doutb; legal range 1..3.
REQ-004 Parameter PAT_OFFSET, default 0, constant added to address to form expected data.
REQ-005 clk  input  1  system clock; single clock domain; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 ram_rd_en  input  1  read enable, as driven to RAM port B.
REQ-008 ram_rd_addr  input  ADDR_W  read address, as driven to RAM port B.
REQ-009 ram_rd_data  input  DATA_W  RAM port B output data.
REQ-010 chk_busy  output  1  high while a check pass is in progress.
REQ-011 chk_done  output  1  high from the end of a pass until the next pass starts.
REQ-012 chk_pass  output  1  valid while chk_done is high; 1 = zero mismatches.
REQ-013 err_cnt  output  ADDR_W+1  mismatch count for the current/last pass.
REQ-014 first_err_addr  output  ADDR_W  address of the first mismatch in the pass.

Function
REQ-015 Expected word SHALL be (zero-extended ram_rd_addr + PAT_OFFSET) mod 2^DATA_W.
REQ-016 The block SHALL delay ram_rd_en and ram_rd_addr through exactly RD_LAT register stages to form cmp_vld/cmp_addr aligned with ram_rd_data.
REQ-017 A compare SHALL occur on every cycle cmp_vld=1; ram_rd_data is ignored when cmp_vld=0.
REQ-018 FSM states SHALL be IDLE, CHECK, DONE.
REQ-019 IDLE->CHECK on ram_rd_en=1; err_cnt, word counter, first_err_addr and chk_done cleared on that edge.
REQ-020 CHECK->DONE on the cycle the 2^ADDR_W-th compare completes; chk_done and chk_pass update on the following edge.
REQ-021 DONE->CHECK on ram_rd_en=1 (new pass), clearing counters as in REQ-019; compares still draining from the previous pass SHALL be counted in the previous pass only.
REQ-022 Gaps in ram_rd_en during CHECK SHALL stall counting without error; no timeout.
REQ-023 On a mismatch, err_cnt SHALL increment by 1, saturating at 2^(ADDR_W+1)-1.
REQ-024 first_err_addr SHALL capture cmp_addr on the first mismatch of a pass only; held at 0 if none.
REQ-025 chk_pass SHALL be 1 only when chk_done=1 and err_cnt=0.
REQ-026 chk_busy SHALL equal (state==CHECK).
REQ-027 Address wrap (ADDR_W'max -> 0) within a pass SHALL be compared normally; the pass ends by word count, not address.

Reset
REQ-028 On rst_n=0, all outputs, delay stages, counters and FSM (IDLE) SHALL clear to 0 asynchronously.
REQ-029 Reset asserted mid-pass SHALL abandon the pass; no chk_done is produced for it.
REQ-030 The first ram_rd_en after reset release SHALL start a pass normally.

Configuration
REQ-031 Macro RAM_RD_CHK_ERR_INJ_EN: when defined, adds input err_inj (1 bit); while err_inj=1 and cmp_vld=1, the LSB of the compared data SHALL be inverted before comparison.
REQ-032 Without RAM_RD_CHK_ERR_INJ_EN the err_inj port SHALL not exist and compare data is ram_rd_data unmodified.

Verification
REQ-033 RAM preloaded data=addr, 64 consecutive reads addr 0..63, RD_LAT=1 -> chk_done=1 one cycle after last compare, chk_pass=1, err_cnt=0.
REQ-034 Word at addr 17 = 0xFF, others correct -> err_cnt=1, first_err_addr=17, chk_pass=0.
REQ-035 Words at addr 5 and 40 corrupt, reads with random 0-3 cycle gaps -> err_cnt=2, first_err_addr=5, no false errors during gaps.
REQ-036 rst_n pulsed low after 30 reads, then full pass restarted -> chk_done stays 0 until new pass ends; err_cnt reflects only new pass.
REQ-037 RAM_RD_CHK_ERR_INJ_EN defined, err_inj=1 for addresses 10..12 on clean data -> err_cnt=3, first_err_addr=10.
REQ-038 Back-to-back passes, second starting the cycle after the last read of the first, RD_LAT=2 -> first pass chk_pass=1, second pass counts exactly 64 words.
